fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/fifo_wr_arbiter_if.sv | 25 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int unsigned MAX_REQ   = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // OR of the indices of set bits; exact for a one-hot or all-zero vector.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake and FIFO write-port signals of the write arbiter.
interface fifo_wr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wfull;
    logic [DATA_WIDTH-1:0]         wdata;
    logic                          winc;
    logic [NUM_REQ-1:0]            grant;
    logic                          burst_trunc;

    modport master (
        input  req_valid, req_data, req_last, wfull,
        output req_ready, wdata, winc, grant, burst_trunc
    );

    modport slave (
        output req_valid, req_data, req_last, wfull,
        input  req_ready, wdata, winc, grant, burst_trunc
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible request at or above ptr, wrapping.
module rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] exclude,
    output logic               found,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   j;

    assign cand = req & ~exclude;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        j     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && cand[j]) begin
                found   = 1'b1;
                pick[j] = 1'b1;
                idx     = j;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async-FIFO write port between requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic              wclk,
    input  logic              wrst,
    fifo_wr_arbiter_if.master bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               trunc_q, trunc_d;

    logic [IDX_W-1:0]      owner, owner_next;
    logic [IDX_W-1:0]      pick_ptr;
    logic [NUM_REQ-1:0]    pick_excl, pick;
    logic                  pick_found;
    logic [IDX_W-1:0]      unused_pick_idx;
    logic [NUM_REQ-1:0]    ready_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic                  winc_c;
    logic                  burst_end;

    assign owner      = IDX_W'(onehot_to_idx(MAX_REQ'(grant_q)));
    assign owner_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

    // At burst end the search starts past the owner and skips it; in IDLE it starts at rr_ptr.
    assign pick_ptr  = (state_q == BURST) ? owner_next : rr_ptr_q;
    assign pick_excl = (state_q == BURST) ? grant_q : '0;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req     (bus.req_valid),
        .ptr     (pick_ptr),
        .exclude (pick_excl),
        .found   (pick_found),
        .pick    (pick),
        .idx     (unused_pick_idx)
    );

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            trunc_q    <= trunc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        trunc_d    = 1'b0;
        ready_c    = '0;
        wdata_c    = '0;
        winc_c     = 1'b0;
        burst_end  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = BURST;
                    grant_d    = pick;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                ready_c[owner] = !bus.wfull;
                wdata_c        = bus.req_data[32'(owner) * DATA_WIDTH +: DATA_WIDTH];
                winc_c         = bus.req_valid[owner] && !bus.wfull;
                if (winc_c) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    burst_end  = bus.req_last[owner] ||
                                 (beat_cnt_q == CNT_W'(MAX_BURST - 1));
                end
                if (burst_end) begin
                    rr_ptr_d   = owner_next;
                    trunc_d    = !bus.req_last[owner];
                    beat_cnt_d = '0;
                    if (pick_found) begin
                        grant_d = pick;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign bus.req_ready   = ready_c;
    assign bus.wdata       = wdata_c;
    assign bus.winc        = winc_c;
    assign bus.grant       = grant_q;
    assign bus.burst_trunc = trunc_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a per-cycle arbitration model and a write-order scoreboard.
module tb_fifo_wr_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned MB = 8;

    logic wclk = 1'b0;
    logic wrst;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_miscmp = 0;

    // Reference state: owner index (-1 when idle), beats in current grant, rotation start.
    int m_owner, m_cnt, m_rr;
    bit m_trunc;

    // Requester sources: burst length, position, idle gap, next sequence number.
    int s_len [NR];
    int s_pos [NR];
    int s_gap [NR];
    int s_seq [NR];
    int sb_seq[NR];

    logic [NR-1:0] en;
    int unsigned   vprob, fprob;
    int dut_writes = 0, mdl_writes = 0, dut_truncs = 0, mdl_truncs = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_choose(input logic [NR-1:0] v, input int start, input int excl);
        for (int k = 0; k < int'(NR); k++) begin
            int j;
            j = (start + k) % int'(NR);
            if (v[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_rr    = 0;
        m_trunc = 1'b0;
    endtask

    task automatic step();
        logic [NR*DW-1:0] rd;
        logic [NR-1:0]    v, l, er, eg, acc;
        logic             full, ew;
        logic [DW-1:0]    ed;
        int id, p, nx_owner, nx_cnt, nx_rr;
        bit nx_trunc;

        @(negedge wclk);
        for (int i = 0; i < int'(NR); i++) begin
            v[i] = en[i] && (s_gap[i] == 0) && ($urandom_range(0, 99) < vprob);
            rd[i*DW +: DW] = {8'(i), 24'(s_seq[i])};
            l[i] = (s_pos[i] == s_len[i] - 1);
        end
        full = ($urandom_range(0, 99) < fprob);
        bus.req_valid = v;
        bus.req_data  = rd;
        bus.req_last  = l;
        bus.wfull     = full;
        #1;

        er = '0;
        eg = '0;
        ew = 1'b0;
        ed = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            er[m_owner] = !full;
            ew = v[m_owner] && !full;
            ed = rd[m_owner*DW +: DW];
        end
        check("grant", 64'(bus.grant), 64'(eg));
        check("req_ready", 64'(bus.req_ready), 64'(er));
        check("winc", 64'(bus.winc), 64'(ew));
        check("wdata", 64'(bus.wdata), 64'(ed));
        check("burst_trunc", 64'(bus.burst_trunc), 64'(m_trunc));

        // Every FIFO write must be the next beat of the requester it came from.
        if (bus.winc === 1'b1) begin
            dut_writes++;
            id = int'(bus.wdata[31:24]);
            check("wr_id_range", 64'(id < int'(NR)), 64'(1));
            if (id < int'(NR)) begin
                check("wr_seq", 64'(bus.wdata[23:0]), 64'(24'(sb_seq[id])));
                sb_seq[id]++;
            end
        end
        if (bus.burst_trunc === 1'b1) dut_truncs++;

        nx_owner = m_owner;
        nx_cnt   = m_cnt;
        nx_rr    = m_rr;
        nx_trunc = 1'b0;
        if (m_owner < 0) begin
            p = rr_choose(v, m_rr, -1);
            if (p >= 0) begin
                nx_owner = p;
                nx_cnt   = 0;
            end
        end else if (ew) begin
            mdl_writes++;
            nx_cnt = m_cnt + 1;
            if (l[m_owner] || nx_cnt == int'(MB)) begin
                nx_rr    = (m_owner + 1) % int'(NR);
                nx_trunc = !l[m_owner];
                if (nx_trunc) mdl_truncs++;
                nx_owner = rr_choose(v, nx_rr, m_owner);
                nx_cnt   = 0;
            end
        end
        acc = er & v;

        @(posedge wclk);
        m_owner = nx_owner;
        m_cnt   = nx_cnt;
        m_rr    = nx_rr;
        m_trunc = nx_trunc;
        for (int i = 0; i < int'(NR); i++) begin
            if (s_gap[i] > 0) begin
                s_gap[i]--;
            end else if (acc[i]) begin
                s_seq[i]++;
                s_pos[i]++;
                if (s_pos[i] == s_len[i]) begin
                    s_pos[i] = 0;
                    s_len[i] = int'($urandom_range(1, 12));
                    s_gap[i] = int'($urandom_range(0, 3));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(NR); i++) begin
            s_len[i]  = int'($urandom_range(1, 12));
            s_pos[i]  = 0;
            s_gap[i]  = 0;
            s_seq[i]  = 0;
            sb_seq[i] = 0;
        end
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.wfull     = 1'b0;
        en    = '0;
        vprob = 100;
        fprob = 0;
        model_reset();

        wrst = 1'b1;
        repeat (2) @(posedge wclk);
        #1;
        check("rst_grant", 64'(bus.grant), 64'(0));
        check("rst_winc", 64'(bus.winc), 64'(0));
        check("rst_ready", 64'(bus.req_ready), 64'(0));
        check("rst_wdata", 64'(bus.wdata), 64'(0));
        check("rst_trunc", 64'(bus.burst_trunc), 64'(0));
        @(negedge wclk);
        wrst = 1'b0;

        // Lone requester 2 with a 3-beat burst, then back-to-back bursts with IDLE gaps.
        en       = 4'b0100;
        s_len[2] = 3;
        repeat (12) step();

        en    = 4'b1111;
        vprob = 90;
        fprob = 5;
        repeat (400) step();

        vprob = 70;
        fprob = 40;
        repeat (300) step();

        // Asynchronous reset between edges while a burst is in progress.
        vprob = 100;
        fprob = 0;
        for (int t = 0; t < 20; t++) begin
            if (m_owner >= 0) break;
            step();
        end
        @(negedge wclk);
        #2;
        wrst = 1'b1;
        #1;
        check("arst_grant", 64'(bus.grant), 64'(0));
        check("arst_winc", 64'(bus.winc), 64'(0));
        check("arst_ready", 64'(bus.req_ready), 64'(0));
        check("arst_trunc", 64'(bus.burst_trunc), 64'(0));
        bus.req_valid = '0;
        model_reset();
        @(posedge wclk);
        @(negedge wclk);
        wrst = 1'b0;

        en       = 4'b0001;
        s_gap[0] = 0;
        repeat (6) step();

        en    = 4'b1111;
        vprob = 85;
        fprob = 20;
        repeat (300) step();

        en = '0;
        repeat (4) step();

        check("write_count", 64'(dut_writes), 64'(mdl_writes));
        check("trunc_count", 64'(dut_truncs), 64'(mdl_truncs));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
